// File: rtl/pong_pkg.sv
// pong_pkg: shared playfield constants, AI state encoding and clamp helper.
package pong_pkg;
  localparam int TOP_BOUNDARY_DEF = 3;
  localparam int BOTTOM_BOUNDARY_DEF = 477;
  localparam int PADDLE_HEIGHT_DEF = 46;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CENTER = 2'd1,
    TRACK  = 2'd2
  } ai_state_t;
  function automatic int y_max_of(input int bottom, input int height);
    return bottom - height;
  endfunction
  function automatic int y_center_of(input int top, input int bottom, input int height);
    return (top + bottom) / 2 - height / 2;
  endfunction
  function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                               input logic signed [10:0] lo,
                                               input logic signed [10:0] hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser plus stability counter for an active-low button.
module button_debounce #(
  parameter logic [16:0] DEBOUNCE_COUNT = 17'd92160
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  logic [1:0] sync;
  logic [16:0] cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b11;
      cnt <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) cnt <= '0;
      else if (cnt == DEBOUNCE_COUNT - 17'd1) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 17'd1;
    end
  end
endmodule

// File: rtl/paddle_control.sv
// paddle_control: player paddle from debounced buttons, AI paddle from a ball-tracking FSM.
module paddle_control import pong_pkg::*; #(
  parameter int TOP_BOUNDARY = TOP_BOUNDARY_DEF,
  parameter int BOTTOM_BOUNDARY = BOTTOM_BOUNDARY_DEF,
  parameter int PADDLE_HEIGHT = PADDLE_HEIGHT_DEF,
  parameter int BALL_SIZE = 7,
  parameter int PLAYER_SPEED = 4,
  parameter int AI_SPEED = 3,
  parameter int AI_DEADZONE = 4,
  parameter int AI_TRACK_X = 320,
  parameter logic [16:0] DEBOUNCE_COUNT = 17'd92160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       button_up_n,
  input  logic       button_down_n,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic [9:0] left_paddle_y,
  output logic [9:0] right_paddle_y,
  output logic [1:0] ai_state
);
  localparam logic signed [10:0] Y_MIN = 11'(TOP_BOUNDARY);
  localparam logic signed [10:0] Y_MAX = 11'(y_max_of(BOTTOM_BOUNDARY, PADDLE_HEIGHT));
  localparam logic signed [10:0] Y_CENTER = 11'(y_center_of(TOP_BOUNDARY, BOTTOM_BOUNDARY, PADDLE_HEIGHT));
  localparam logic signed [10:0] P_STEP = 11'(PLAYER_SPEED);
  localparam logic signed [10:0] AI_STEP = 11'(AI_SPEED);
  localparam logic signed [10:0] AI_DZ = 11'(AI_DEADZONE);
  localparam logic signed [10:0] TRACK_OFS = 11'(BALL_SIZE / 2 - PADDLE_HEIGHT / 2);
  ai_state_t state, next_state;
  logic up_lvl, dn_lvl, up, dn;
  logic signed [10:0] ly, ry, l_next, r_next, target, diff, mag, step;
  button_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_up (
    .clk(clk), .reset(reset), .raw(button_up_n), .level(up_lvl)
  );
  button_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_dn (
    .clk(clk), .reset(reset), .raw(button_down_n), .level(dn_lvl)
  );
  assign up = ~up_lvl;
  assign dn = ~dn_lvl;
  assign ai_state = state;
  always_comb begin
    ly = $signed({1'b0, left_paddle_y});
    ry = $signed({1'b0, right_paddle_y});
    l_next = (up & ~dn) ? clamp(ly - P_STEP, Y_MIN, Y_MAX)
           : (dn & ~up) ? clamp(ly + P_STEP, Y_MIN, Y_MAX) : ly;
    next_state = state == IDLE ? CENTER : (ball_x >= 10'(AI_TRACK_X)) ? TRACK : CENTER;
    // Target follows the state being entered on this tick, not the one being left.
    target = next_state == TRACK ? clamp($signed({1'b0, ball_y}) + TRACK_OFS, Y_MIN, Y_MAX) : Y_CENTER;
    diff = target - ry;
    mag = diff < 0 ? -diff : diff;
    step = mag > AI_STEP ? AI_STEP : mag;
    r_next = (state != IDLE && mag > AI_DZ) ? (diff < 0 ? ry - step : ry + step) : ry;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      left_paddle_y <= 10'(Y_CENTER);
      right_paddle_y <= 10'(Y_CENTER);
    end else if (tick) begin
      state <= next_state;
      left_paddle_y <= 10'(l_next);
      right_paddle_y <= 10'(r_next);
    end
  end
endmodule

// File: tb/tb_paddle_control.sv
// tb_paddle_control: randomized checks of paddle_control against a rule-level model.
module tb_paddle_control;
  localparam logic [16:0] DB = 17'd20;
  logic clk = 0, reset = 0, tick = 0, button_up_n = 1, button_down_n = 1;
  logic [9:0] ball_x = 0, ball_y = 0;
  logic [9:0] left_paddle_y, right_paddle_y;
  logic [1:0] ai_state;
  int total = 0, bad = 0;
  int ml, mr, ms;
  bit mu, md;

  always #5 clk = ~clk;

  paddle_control #(.DEBOUNCE_COUNT(DB)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .button_up_n(button_up_n), .button_down_n(button_down_n),
    .ball_x(ball_x), .ball_y(ball_y),
    .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
    .ai_state(ai_state)
  );

  function automatic int lim(input int v, input int lo, input int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction

  function void model_init();
    ml = 217; mr = 217; ms = 0; mu = 0; md = 0;
  endfunction

  function void model_tick();
    int tgt, d, a;
    if (mu && !md) ml = lim(ml - 4, 3, 431);
    else if (md && !mu) ml = lim(ml + 4, 3, 431);
    if (ms == 0) ms = 1;
    else begin
      ms = (int'(ball_x) >= 320) ? 2 : 1;
      tgt = (ms == 2) ? lim(int'(ball_y) + 3 - 23, 3, 431) : 217;
      d = tgt - mr;
      a = d < 0 ? -d : d;
      if (a > 4) mr = mr + (d < 0 ? -1 : 1) * (a < 3 ? a : 3);
    end
  endfunction

  task automatic do_tick();
    @(negedge clk);
    tick = 1;
    model_tick();
    @(negedge clk);
    tick = 0;
  endtask

  task automatic set_buttons(input logic u, input logic d);
    button_up_n = u;
    button_down_n = d;
    repeat (int'(DB) + 10) @(negedge clk);
    mu = !u;
    md = !d;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    total += 3;
    if (left_paddle_y !== 10'd217) begin bad++; $display("FAIL reset_left got=%0d want=217", left_paddle_y); end
    if (right_paddle_y !== 10'd217) begin bad++; $display("FAIL reset_right got=%0d want=217", right_paddle_y); end
    if (ai_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", ai_state); end
    reset = 1;
    model_init();
    repeat (2) @(negedge clk);
    do_tick();
    total += 3;
    if (ai_state !== 2'd1) begin bad++; $display("FAIL first_tick_state got=%0d want=1", ai_state); end
    if (left_paddle_y !== 10'd217) begin bad++; $display("FAIL first_tick_left got=%0d want=217", left_paddle_y); end
    if (right_paddle_y !== 10'd217) begin bad++; $display("FAIL first_tick_right got=%0d want=217", right_paddle_y); end
  endtask

  task automatic test_player();
    set_buttons(0, 1);
    for (int i = 0; i < 60; i++) begin
      do_tick();
      total++;
      if (int'(left_paddle_y) != ml) begin bad++; $display("FAIL player_up t=%0d got=%0d want=%0d", i, left_paddle_y, ml); end
    end
    total++;
    if (left_paddle_y !== 10'd3) begin bad++; $display("FAIL player_up_sat got=%0d want=3", left_paddle_y); end
    set_buttons(1, 0);
    for (int i = 0; i < 120; i++) begin
      do_tick();
      total++;
      if (int'(left_paddle_y) != ml) begin bad++; $display("FAIL player_down t=%0d got=%0d want=%0d", i, left_paddle_y, ml); end
    end
    total++;
    if (left_paddle_y !== 10'd431) begin bad++; $display("FAIL player_down_sat got=%0d want=431", left_paddle_y); end
    for (int i = 0; i < 20; i++) begin
      set_buttons(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (3) do_tick();
      total++;
      if (int'(left_paddle_y) != ml) begin bad++; $display("FAIL player_rand i=%0d got=%0d want=%0d", i, left_paddle_y, ml); end
    end
  endtask

  task automatic test_glitch_both();
    int y0;
    set_buttons(1, 1);
    for (int i = 0; i < 6; i++) begin
      button_down_n = 0;
      repeat ($urandom_range(1, int'(DB) - 3)) @(negedge clk);
      button_down_n = 1;
      repeat (int'(DB) + 10) @(negedge clk);
      do_tick();
      total++;
      if (int'(left_paddle_y) != ml) begin bad++; $display("FAIL glitch i=%0d got=%0d want=%0d", i, left_paddle_y, ml); end
    end
    set_buttons(0, 0);
    y0 = ml;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      repeat ($urandom_range(0, 4)) @(negedge clk);
      total++;
      if (int'(left_paddle_y) != y0) begin bad++; $display("FAIL both_hold i=%0d got=%0d want=%0d", i, left_paddle_y, y0); end
    end
    set_buttons(1, 1);
  endtask

  task automatic test_ai_track();
    ball_x = 400; ball_y = 100;
    for (int i = 0; i < 60; i++) begin
      do_tick();
      total += 2;
      if (ai_state !== 2'(ms)) begin bad++; $display("FAIL track_state i=%0d got=%0d want=%0d", i, ai_state, ms); end
      if (int'(right_paddle_y) != mr) begin bad++; $display("FAIL track_y i=%0d got=%0d want=%0d", i, right_paddle_y, mr); end
    end
    total += 2;
    if (ai_state !== 2'd2) begin bad++; $display("FAIL track_final_state got=%0d want=2", ai_state); end
    if (int'(right_paddle_y) < 76 || int'(right_paddle_y) > 84) begin bad++; $display("FAIL track_settle got=%0d want=76..84", right_paddle_y); end
  endtask

  task automatic test_ai_clamp();
    ball_y = 5;
    for (int i = 0; i < 60; i++) begin
      do_tick();
      total++;
      if (int'(right_paddle_y) != mr) begin bad++; $display("FAIL clamp_top i=%0d got=%0d want=%0d", i, right_paddle_y, mr); end
    end
    total++;
    if (int'(right_paddle_y) > 7) begin bad++; $display("FAIL clamp_top_settle got=%0d want<=7", right_paddle_y); end
    ball_y = 470;
    for (int i = 0; i < 160; i++) begin
      do_tick();
      total++;
      if (int'(right_paddle_y) != mr || int'(right_paddle_y) > 431) begin bad++; $display("FAIL clamp_bot i=%0d got=%0d want=%0d", i, right_paddle_y, mr); end
    end
    total++;
    if (int'(right_paddle_y) < 427) begin bad++; $display("FAIL clamp_bot_settle got=%0d want>=427", right_paddle_y); end
  endtask

  task automatic test_ai_return();
    ball_x = 100;
    for (int i = 0; i < 90; i++) begin
      do_tick();
      total += 2;
      if (ai_state !== 2'd1) begin bad++; $display("FAIL return_state i=%0d got=%0d want=1", i, ai_state); end
      if (int'(right_paddle_y) != mr) begin bad++; $display("FAIL return_y i=%0d got=%0d want=%0d", i, right_paddle_y, mr); end
    end
    total++;
    if (int'(right_paddle_y) < 213 || int'(right_paddle_y) > 221) begin bad++; $display("FAIL return_settle got=%0d want=213..221", right_paddle_y); end
  endtask

  task automatic test_ai_random();
    for (int i = 0; i < 150; i++) begin
      ball_x = 10'($urandom_range(0, 639));
      ball_y = 10'($urandom_range(0, 479));
      do_tick();
      total += 3;
      if (ai_state !== 2'(ms)) begin bad++; $display("FAIL rand_state i=%0d got=%0d want=%0d", i, ai_state, ms); end
      if (int'(right_paddle_y) != mr) begin bad++; $display("FAIL rand_right i=%0d got=%0d want=%0d", i, right_paddle_y, mr); end
      if (int'(left_paddle_y) != ml) begin bad++; $display("FAIL rand_left i=%0d got=%0d want=%0d", i, left_paddle_y, ml); end
    end
  endtask

  task automatic test_async_reset();
    ball_x = 500; ball_y = 30;
    repeat (10) do_tick();
    @(negedge clk);
    #2 reset = 0;
    #1;
    total += 3;
    if (left_paddle_y !== 10'd217) begin bad++; $display("FAIL async_left got=%0d want=217", left_paddle_y); end
    if (right_paddle_y !== 10'd217) begin bad++; $display("FAIL async_right got=%0d want=217", right_paddle_y); end
    if (ai_state !== 2'd0) begin bad++; $display("FAIL async_state got=%0d want=0", ai_state); end
    @(negedge clk);
    reset = 1;
    model_init();
    repeat (12) do_tick();
    total += 3;
    if (ai_state !== 2'(ms)) begin bad++; $display("FAIL post_reset_state got=%0d want=%0d", ai_state, ms); end
    if (int'(right_paddle_y) != mr) begin bad++; $display("FAIL post_reset_right got=%0d want=%0d", right_paddle_y, mr); end
    if (int'(left_paddle_y) != ml) begin bad++; $display("FAIL post_reset_left got=%0d want=%0d", left_paddle_y, ml); end
  endtask

  initial begin
    test_reset();
    test_player();
    test_glitch_both();
    test_ai_track();
    test_ai_clamp();
    test_ai_return();
    test_ai_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
